// File: rtl/toggle_counter.sv
// WIDTH-bit synchronous counter/toggle register: hold, count up/down modulo MODULUS,
// toggle a bit mask, or load a value. All updates occur on a single clock edge.
module toggle_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
      64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("toggle_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] cand;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    cand   = '0;
    case (mode)
      2'b01: begin
        if (up) begin
          if (q_q == MaxVal) begin
            if (!SATURATE) begin
              q_d    = '0;
              wrap_d = 1'b1;
            end
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end else begin
          if (q_q == '0) begin
            if (!SATURATE) begin
              q_d    = MaxVal;
              wrap_d = 1'b1;
            end
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
      end
      2'b10: begin
        cand = q_q ^ T;
        q_d  = (cand > MaxVal) ? MaxVal : cand;
      end
      2'b11: begin
        cand = D;
        q_d  = (cand > MaxVal) ? MaxVal : cand;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // notQ is derived, never stored, so it cannot disagree with Q.
  assign Q    = q_q;
  assign notQ = ~q_q;
  assign wrap = wrap_q;
  assign tc   = up ? (q_q == MaxVal) : (q_q == '0);

endmodule

// File: tb/tb_toggle_counter.sv
// Table-driven bench for toggle_counter: three configurations, expected results
// queued at drive time and popped after the clock edge.
module tb_toggle_counter;

  typedef struct {
    int unsigned dut;
    logic        rst;
    logic [1:0]  mode;
    logic        up;
    logic [3:0]  t;
    logic [3:0]  d;
    logic [3:0]  q;
    logic        wrap;
    logic        tc;
  } vec_t;

  typedef struct {
    int unsigned dut;
    int          idx;
    logic [3:0]  q;
    logic        wrap;
    logic        tc;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: WIDTH=4 MODULUS=10 wrap; 1: WIDTH=4 MODULUS=10 saturate; 2: WIDTH=3 MODULUS=8
  logic       rst_a, rst_b, rst_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic       up_a, up_b, up_c;
  logic [3:0] t_a, t_b, d_a, d_b;
  logic [2:0] t_c, d_c;
  logic [3:0] q_a, q_b, nq_a, nq_b;
  logic [2:0] q_c, nq_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;

  toggle_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .mode(mode_a), .up(up_a), .T(t_a), .D(d_a),
    .Q(q_a), .notQ(nq_a), .tc(tc_a), .wrap(wrap_a)
  );
  toggle_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .mode(mode_b), .up(up_b), .T(t_b), .D(d_b),
    .Q(q_b), .notQ(nq_b), .tc(tc_b), .wrap(wrap_b)
  );
  toggle_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_c (
    .clk(clk), .reset(rst_c), .mode(mode_c), .up(up_c), .T(t_c), .D(d_c),
    .Q(q_c), .notQ(nq_c), .tc(tc_c), .wrap(wrap_c)
  );

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input int unsigned dut, input logic rst, input logic [1:0] mode,
                     input logic up, input logic [3:0] t, input logic [3:0] d,
                     input logic [3:0] q, input logic wrap, input logic tc);
    vec_t v;
    v.dut = dut; v.rst = rst; v.mode = mode; v.up = up; v.t = t; v.d = d;
    v.q = q; v.wrap = wrap; v.tc = tc;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e, got;
    logic [3:0] aq, anq;
    logic       aw, atc;
    @(negedge clk);
    {rst_a, rst_b, rst_c} = '0;
    {mode_a, mode_b, mode_c} = '0;
    case (v.dut)
      0: begin rst_a = v.rst; mode_a = v.mode; up_a = v.up; t_a = v.t; d_a = v.d; end
      1: begin rst_b = v.rst; mode_b = v.mode; up_b = v.up; t_b = v.t; d_b = v.d; end
      default: begin
        rst_c = v.rst; mode_c = v.mode; up_c = v.up; t_c = v.t[2:0]; d_c = v.d[2:0];
      end
    endcase
    e.dut = v.dut; e.idx = idx; e.q = v.q; e.wrap = v.wrap; e.tc = v.tc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    case (got.dut)
      0: begin aq = q_a; anq = nq_a; aw = wrap_a; atc = tc_a; end
      1: begin aq = q_b; anq = nq_b; aw = wrap_b; atc = tc_b; end
      default: begin aq = {1'b0, q_c}; anq = {1'b0, nq_c}; aw = wrap_c; atc = tc_c; end
    endcase
    cmp("Q", got.idx, aq, got.q);
    cmp("notQ", got.idx, anq, (got.dut == 2) ? {1'b0, ~got.q[2:0]} : ~got.q);
    cmp("wrap", got.idx, {3'b0, aw}, {3'b0, got.wrap});
    cmp("tc", got.idx, {3'b0, atc}, {3'b0, got.tc});
  endtask

  initial begin
    vec_t hv;
    {rst_a, rst_b, rst_c} = 3'b111;
    {mode_a, mode_b, mode_c} = '0;
    {up_a, up_b, up_c} = 3'b111;
    {t_a, t_b, d_a, d_b} = '0;
    {t_c, d_c} = '0;

    // A: reset, count up through the wrap, count down through the wrap
    add(0, 1, 2'b00, 1, 4'h0, 4'h0, 4'd0, 0, 0);
    for (int i = 1; i <= 9; i++) add(0, 0, 2'b01, 1, 4'h0, 4'h0, 4'(i), 0, (i == 9));
    add(0, 0, 2'b01, 1, 4'h0, 4'h0, 4'd0, 1, 0);
    add(0, 0, 2'b01, 1, 4'h0, 4'h0, 4'd1, 0, 0);
    add(0, 0, 2'b01, 1, 4'h0, 4'h0, 4'd2, 0, 0);
    add(0, 0, 2'b01, 0, 4'h0, 4'h0, 4'd1, 0, 0);
    add(0, 0, 2'b01, 0, 4'h0, 4'h0, 4'd0, 0, 1);
    add(0, 0, 2'b01, 0, 4'h0, 4'h0, 4'd9, 1, 0);
    add(0, 0, 2'b01, 0, 4'h0, 4'h0, 4'd8, 0, 0);
    add(0, 0, 2'b00, 0, 4'h0, 4'h0, 4'd8, 0, 0);
    // A: load/toggle clamps
    add(0, 0, 2'b11, 1, 4'h0, 4'd13, 4'd9, 0, 1);
    add(0, 0, 2'b11, 1, 4'h0, 4'd5, 4'd5, 0, 0);
    add(0, 0, 2'b10, 1, 4'b1010, 4'h0, 4'd9, 0, 1);
    add(0, 0, 2'b11, 1, 4'h0, 4'd5, 4'd5, 0, 0);
    add(0, 0, 2'b10, 1, 4'b0011, 4'h0, 4'd6, 0, 0);
    add(0, 0, 2'b10, 1, 4'b0000, 4'h0, 4'd6, 0, 0);
    add(0, 0, 2'b11, 1, 4'h0, 4'd9, 4'd9, 0, 1);
    add(0, 0, 2'b01, 1, 4'h0, 4'h0, 4'd0, 1, 0);
    add(0, 0, 2'b00, 1, 4'h0, 4'h0, 4'd0, 0, 0);
    // B: saturating ends
    add(1, 1, 2'b00, 1, 4'h0, 4'h0, 4'd0, 0, 0);
    add(1, 0, 2'b11, 1, 4'h0, 4'd9, 4'd9, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 2'b01, 1, 4'h0, 4'h0, 4'd9, 0, 1);
    add(1, 0, 2'b11, 0, 4'h0, 4'd0, 4'd0, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 0, 2'b01, 0, 4'h0, 4'h0, 4'd0, 0, 1);
    add(1, 0, 2'b01, 1, 4'h0, 4'h0, 4'd1, 0, 0);
    add(1, 0, 2'b11, 1, 4'h0, 4'd15, 4'd9, 0, 1);
    // C: full binary range, no clamp
    add(2, 1, 2'b00, 1, 4'h0, 4'h0, 4'd0, 0, 0);
    for (int i = 1; i <= 7; i++) add(2, 0, 2'b01, 1, 4'h0, 4'h0, 4'(i), 0, (i == 7));
    add(2, 0, 2'b01, 1, 4'h0, 4'h0, 4'd0, 1, 0);
    add(2, 0, 2'b01, 1, 4'h0, 4'h0, 4'd1, 0, 0);
    add(2, 0, 2'b11, 1, 4'h0, 4'd7, 4'd7, 0, 1);
    add(2, 0, 2'b01, 1, 4'h0, 4'h0, 4'd0, 1, 0);
    add(2, 0, 2'b01, 0, 4'h0, 4'h0, 4'd7, 1, 0);
    add(2, 0, 2'b01, 0, 4'h0, 4'h0, 4'd6, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset overriding a load mid-count, then resuming.
    hv = '{dut: 0, rst: 0, mode: 2'b11, up: 1, t: 4'h0, d: 4'd3, q: 4'd3, wrap: 0, tc: 0};
    apply(hv, 100);
    hv = '{dut: 0, rst: 0, mode: 2'b01, up: 1, t: 4'h0, d: 4'd0, q: 4'd4, wrap: 0, tc: 0};
    apply(hv, 101);
    hv = '{dut: 0, rst: 1, mode: 2'b11, up: 1, t: 4'h0, d: 4'd7, q: 4'd0, wrap: 0, tc: 0};
    apply(hv, 102);
    hv = '{dut: 0, rst: 0, mode: 2'b01, up: 1, t: 4'h0, d: 4'd0, q: 4'd1, wrap: 0, tc: 0};
    apply(hv, 103);

    // tc follows up combinationally with Q held at 0.
    hv = '{dut: 0, rst: 1, mode: 2'b00, up: 1, t: 4'h0, d: 4'd0, q: 4'd0, wrap: 0, tc: 0};
    apply(hv, 104);
    @(negedge clk);
    {rst_a, mode_a} = '0;
    up_a = 1'b0;
    #1 cmp("tc_comb_down", 105, {3'b0, tc_a}, 4'd1);
    up_a = 1'b1;
    #1 cmp("tc_comb_up", 106, {3'b0, tc_a}, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit synchronous register that can hold, count up or down modulo MODULUS, toggle an arbitrary bit mask, or load a value. It replaces chains of discrete toggle flip-flops in counters, dividers and sequencers. All state changes on one clock edge, so there is no ripple.

## Interface
- WIDTH, 4: register width in bits; minimum 1.
- MODULUS, 16: count range 0..MODULUS-1.
  - Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
  - Elaboration error outside this range.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high; the only reset.
- mode  in  2  00 hold, 01 count, 10 toggle-mask, 11 load.
- up  in  1  count direction when mode=01: 1 up, 0 down.
- T  in  WIDTH  per-bit toggle mask, used when mode=10.
- D  in  WIDTH  load value, used when mode=11.
- Q  out  WIDTH  registered state.
- notQ  out  WIDTH  always the bitwise complement of Q.
- tc  out  1  combinational terminal count for the current direction.
- wrap  out  1  registered one-cycle pulse marking a wrap step.

## Operation
- Priority at each rising edge: reset, then mode. mode, up, T and D are sampled only at that edge.
- Hold (00):
  - Q unchanged.
  - wrap <= 0.
- Count (01), up=1:
  - If Q == MODULUS-1 and SATURATE=0: Q <= 0 and wrap <= 1.
  - If Q == MODULUS-1 and SATURATE=1: Q holds and wrap <= 0.
  - Otherwise: Q <= Q+1 and wrap <= 0.
- Count (01), up=0:
  - If Q == 0 and SATURATE=0: Q <= MODULUS-1 and wrap <= 1.
  - If Q == 0 and SATURATE=1: Q holds and wrap <= 0.
  - Otherwise: Q <= Q-1 and wrap <= 0.
- Toggle-mask (10):
  - Candidate value is Q ^ T. Each bit of T behaves like the T input of a toggle flip-flop.
  - T = all zeros is equivalent to hold.
  - wrap <= 0.
- Load (11):
  - Candidate value is D.
  - wrap <= 0.
- Clamp rule: in toggle-mask and load, any candidate ≥ MODULUS is written as MODULUS-1. Q is therefore always in range, and count mode never sees an out-of-range value.
- Arithmetic:
  - Comparisons are unsigned and WIDTH bits wide.
  - When MODULUS = 2^WIDTH the clamp can never fire, and wrapping is plain binary overflow.
- tc = (up && Q == MODULUS-1) || (!up && Q == 0).
  - tc depends only on Q and up, not on mode or SATURATE.
- notQ is derived from Q, never stored separately, so Q and notQ cannot disagree.

## Timing
- Reset values after a clock edge with reset=1:
  - Q = 0.
  - notQ = all ones.
  - wrap = 0.
  - tc = 1 if up=0, else tc = (MODULUS-1 == 0), which is 0 for any legal MODULUS.
- Reset mid-operation overrides mode on that edge. No partial update and no wrap pulse are produced.
- Latency:
  - Q changes one clock after the command is sampled.
  - wrap is asserted in the same cycle that Q shows the wrapped value, and lasts exactly one cycle unless the next edge wraps again.
- Back-to-back commands: any mode sequence is legal on consecutive cycles with no idle cycle needed. For example, load then count gives D', then D'±1 on the next cycle (D' is the clamped load value).
- Combinational paths:
  - tc follows up within the same cycle.
  - There is no combinational path from mode, T or D to any output.
- Modulus 2 in count mode alternates 0,1,0,1, matching a toggle flip-flop with T=1 when WIDTH=1.

## Test plan
- Reset and count up (WIDTH=4, MODULUS=10, SATURATE=0):
  - Reset, then mode=01, up=1 for 12 cycles -> Q goes 1..9, 0, 1, 2.
  - wrap is high only in the cycle Q becomes 0.
  - tc is high while Q=9.
- Count down wrap (same configuration):
  - From Q=0, mode=01, up=0 -> Q=9 and wrap=1.
  - Next cycle -> Q=8 and wrap=0.
  - tc was high while Q=0.
- Saturate (SATURATE=1, MODULUS=10):
  - Load 9, then count up 3 cycles -> Q stays 9 and wrap stays 0.
  - Load 0, then count down -> Q stays 0.
- Load and toggle clamp (MODULUS=10):
  - Load D=13 -> Q=9.
  - Load 5, then toggle T=4'b1010 -> Q'=4'b1111 clamps to 9.
  - Load 5, then toggle T=4'b0011 -> Q=6.
  - notQ = ~Q in every cycle.
- Reset mid-operation:
  - Count up from 3, assert reset on the edge where a load of 7 is requested -> Q=0, wrap=0, notQ=4'hF.
  - Release reset, count up -> Q=1.
- Full-range binary (WIDTH=3, MODULUS=8):
  - Count up 9 cycles from reset -> Q goes 1..7, 0, 1, with one wrap pulse.
  - Load 3'b111 -> Q=7 (no clamp).
